// File: rtl/efuse_ctrl.sv
// efuse_ctrl: electronic fuse / load-switch controller with soft-start,
// timed and instant overcurrent trips, reverse-polarity protection and
// optional auto-retry (enabled by defining EFUSE_AUTO_RETRY_EN).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   en           in   power request (level)
//   rev_pol      in   reverse input polarity detected
//   current_ma   in   [11:0] load current sample, unsigned mA
//   sample_valid in   current_ma valid this cycle
//   gate_on      out  load-switch drive (SOFTSTART, ON)
//   powered      out  power-good (ON)
//   fault        out  in RETRY_WAIT or LATCHED
//   fault_code   out  [1:0] 00 none, 01 timed OC, 10 short, 11 reverse polarity
//   trip_count   out  [7:0] trips since reset, saturating
module efuse_ctrl #(
    parameter int TRIP_MA          = 500,
    parameter int SHORT_MA         = 1500,
    parameter int BLOW_CYCLES      = 1000,
    parameter int SOFTSTART_CYCLES = 16,
    parameter int RETRY_CYCLES     = 256,
    parameter int MAX_RETRIES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        rev_pol,
    input  logic [11:0] current_ma,
    input  logic        sample_valid,
    output logic        gate_on,
    output logic        powered,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [7:0]  trip_count
);
    typedef enum logic [2:0] {OFF, SOFTSTART, ON, RETRY_WAIT, LATCHED} state_t;

    // One shared timer covers both the soft-start and the cool-down phases.
    localparam int TW = $clog2((SOFTSTART_CYCLES > RETRY_CYCLES ? SOFTSTART_CYCLES : RETRY_CYCLES) + 1);
    localparam int OW = $clog2(BLOW_CYCLES + 1);
    localparam logic [11:0] TRIP_L  = 12'(TRIP_MA);
    localparam logic [11:0] SHORT_L = 12'(SHORT_MA);
    localparam logic [TW-1:0] SS_END = TW'(SOFTSTART_CYCLES - 1);
    localparam logic [TW-1:0] RT_END = TW'(RETRY_CYCLES - 1);
    localparam logic [OW-1:0] OC_END = OW'(BLOW_CYCLES - 1);

    state_t        state_q, state_d, dest;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [OW-1:0] oc_q, oc_d, oc_next;
    logic [1:0]    code_q, code_d, code_trip;
    logic [7:0]    trips_q, trips_d;
    logic          gate_q, gate_d, pwr_q, pwr_d, fault_q, fault_d;
    logic          live, over, short_hit, blow, trip;

`ifdef EFUSE_AUTO_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retry_q, retry_d;
    assign dest = (retry_q == RW'(MAX_RETRIES)) ? LATCHED : RETRY_WAIT;
`else
    localparam int unused_max_retries = MAX_RETRIES;
    assign dest = LATCHED;
`endif

    assign live      = (state_q == SOFTSTART) || (state_q == ON);
    assign over      = sample_valid && (current_ma > TRIP_L);
    assign short_hit = sample_valid && (current_ma >= SHORT_L);
    // The sample that would make the run BLOW_CYCLES long trips immediately.
    assign blow      = over && (oc_q == OC_END);
    assign trip      = live && (rev_pol || short_hit || blow);
    assign code_trip = rev_pol ? 2'b11 : short_hit ? 2'b10 : 2'b01;
    assign oc_next   = !sample_valid ? oc_q : over ? oc_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            tmr_q   <= '0;
            oc_q    <= '0;
            code_q  <= '0;
            trips_q <= '0;
            gate_q  <= 1'b0;
            pwr_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            oc_q    <= oc_d;
            code_q  <= code_d;
            trips_q <= trips_d;
            gate_q  <= gate_d;
            pwr_q   <= pwr_d;
            fault_q <= fault_d;
        end
    end

`ifdef EFUSE_AUTO_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) retry_q <= '0;
        else     retry_q <= retry_d;
    end

    always_comb begin
        retry_d = retry_q;
        if (!en)       retry_d = '0;
        else if (trip) retry_d = retry_q + 1'b1;
    end
`endif

    // en=0 outranks every trip, a trip outranks normal sequencing.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        oc_d    = oc_q;
        code_d  = code_q;
        trips_d = trips_q;
        if (!en) begin
            state_d = OFF;
            tmr_d   = '0;
            oc_d    = '0;
        end else if (trip) begin
            state_d = dest;
            tmr_d   = '0;
            oc_d    = '0;
            code_d  = code_trip;
            trips_d = (trips_q == 8'hFF) ? trips_q : trips_q + 8'd1;
        end else begin
            case (state_q)
                OFF: begin
                    if (rev_pol) code_d = 2'b11;
                    else begin
                        state_d = SOFTSTART;
                        tmr_d   = '0;
                    end
                end
                SOFTSTART: begin
                    oc_d = oc_next;
                    if (tmr_q == SS_END) begin
                        state_d = ON;
                        tmr_d   = '0;
                        code_d  = 2'b00;
                    end else tmr_d = tmr_q + 1'b1;
                end
                ON: oc_d = oc_next;
                RETRY_WAIT: begin
                    if (tmr_q == RT_END) begin
                        state_d = rev_pol ? OFF : SOFTSTART;
                        tmr_d   = '0;
                    end else tmr_d = tmr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered with it.
    always_comb begin
        gate_d  = (state_d == SOFTSTART) || (state_d == ON);
        pwr_d   = (state_d == ON);
        fault_d = (state_d == RETRY_WAIT) || (state_d == LATCHED);
    end

    assign gate_on    = gate_q;
    assign powered    = pwr_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign trip_count = trips_q;
endmodule

// File: tb/tb_efuse_ctrl.sv
// tb_efuse_ctrl: scoreboard bench for efuse_ctrl with a behavioural model.
module tb_efuse_ctrl;
    localparam int TRIP  = 500;
    localparam int SHORT = 1500;
    localparam int BLOW  = 1000;
    localparam int SSC   = 16;
    localparam int RTC   = 256;
    localparam int MAXR  = 3;
    localparam int S_OFF = 0, S_SS = 1, S_ON = 2, S_RW = 3, S_LAT = 4;

    logic        clk = 1'b0;
    logic        rst, en, rev_pol, sample_valid;
    logic [11:0] current_ma;
    logic        gate_on, powered, fault;
    logic [1:0]  fault_code;
    logic [7:0]  trip_count;

    typedef struct packed {
        logic       g;
        logic       p;
        logic       f;
        logic [1:0] c;
        logic [7:0] t;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    string phase = "reset";
    exp_t  mx;
    string mt;
    int    vectors = 0, miscompares = 0;
    int    st, left, run, retries, trips, code;

    efuse_ctrl #(
        .TRIP_MA(TRIP), .SHORT_MA(SHORT), .BLOW_CYCLES(BLOW),
        .SOFTSTART_CYCLES(SSC), .RETRY_CYCLES(RTC), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rev_pol(rev_pol),
        .current_ma(current_ma), .sample_valid(sample_valid),
        .gate_on(gate_on), .powered(powered), .fault(fault),
        .fault_code(fault_code), .trip_count(trip_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t x;
        x.g = (st == S_SS) || (st == S_ON);
        x.p = (st == S_ON);
        x.f = (st == S_RW) || (st == S_LAT);
        x.c = 2'(code);
        x.t = 8'(trips);
        return x;
    endfunction

    task automatic model_reset();
        st = S_OFF; left = 0; run = 0; retries = 0; trips = 0; code = 0;
    endtask

    task automatic model_update(input logic e, input logic r, input int c, input logic v);
        int nrun;
        bit live, sh;
        nrun = v ? (c > TRIP ? run + 1 : 0) : run;
        live = (st == S_SS) || (st == S_ON);
        sh   = v && (c >= SHORT);
        if (!e) begin
            st = S_OFF; run = 0; retries = 0; left = 0;
        end else if (live && (r || sh || nrun >= BLOW)) begin
            code = r ? 3 : sh ? 2 : 1;
            if (trips < 255) trips++;
            run = 0;
`ifdef EFUSE_AUTO_RETRY_EN
            if (retries == MAXR) st = S_LAT;
            else begin st = S_RW; left = RTC; end
`else
            st = S_LAT;
`endif
            retries++;
        end else if (st == S_OFF) begin
            if (r) code = 3;
            else begin st = S_SS; left = SSC; run = 0; end
        end else if (st == S_SS) begin
            run = nrun;
            left--;
            if (left == 0) begin st = S_ON; code = 0; end
        end else if (st == S_ON) begin
            run = nrun;
        end else if (st == S_RW) begin
            left--;
            if (left == 0) begin
                if (r) st = S_OFF;
                else begin st = S_SS; left = SSC; end
            end
        end
    endtask

    task automatic cmp(input exp_t x, input string tag);
        vectors++;
        if ({gate_on, powered, fault, fault_code, trip_count} !== x) begin
            miscompares++;
            $display("FAIL %s @%0t: got gate=%b pwr=%b fault=%b code=%b trips=%0d, want gate=%b pwr=%b fault=%b code=%b trips=%0d",
                     tag, $time, gate_on, powered, fault, fault_code, trip_count, x.g, x.p, x.f, x.c, x.t);
        end
    endtask

    task automatic step(input logic e, input logic r, input int c, input logic v);
        @(negedge clk);
        en = e; rev_pol = r; current_ma = 12'(c); sample_valid = v;
        model_update(e, r, c, v);
        q.push_back(model_out());
        tq.push_back(phase);
        @(posedge clk);
    endtask

    task automatic to_on();
        step(1'b0, 1'b0, 0, 1'b0);
        repeat (SSC + 1) step(1'b1, 1'b0, 120, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mx = q.pop_front();
            mt = tq.pop_front();
            cmp(mx, mt);
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; rev_pol = 1'b0; current_ma = '0; sample_valid = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #10 cmp(model_out(), "reset_state");
        @(negedge clk) rst = 1'b0;

        phase = "softstart_120";
        repeat (30) step(1'b1, 1'b0, 120, 1'b1);

        phase = "on_480";
        repeat (2000) step(1'b1, 1'b0, 480, 1'b1);
        phase = "short_2000";
        step(1'b1, 1'b0, 2000, 1'b1);
        phase = "after_short";
        repeat (300) step(1'b1, 1'b0, $urandom_range(0, 2500), 1'($urandom_range(0, 1)));
        phase = "en_off";
        repeat (3) step(1'b0, 1'b0, 0, 1'b0);

        phase = "timed_oc";
        to_on();
        repeat (999) step(1'b1, 1'b0, 600, 1'b1);
        step(1'b1, 1'b0, 400, 1'b1);
        repeat (1000) step(1'b1, 1'b0, 600, 1'b1);
        repeat (5) step(1'b1, 1'b0, 120, 1'b1);

        phase = "timed_oc_hold";
        to_on();
        repeat (500) step(1'b1, 1'b0, 600, 1'b1);
        repeat (50) step(1'b1, 1'b0, 3000, 1'b0);
        repeat (501) step(1'b1, 1'b0, 600, 1'b1);

        phase = "revpol_off";
        step(1'b0, 1'b0, 0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 120, 1'b1);
        phase = "revpol_on";
        repeat (SSC + 3) step(1'b1, 1'b0, 120, 1'b1);
        step(1'b1, 1'b1, 120, 1'b1);
        repeat (3) step(1'b1, 1'b0, 120, 1'b1);

        phase = "prio_rev_short";
        to_on();
        step(1'b1, 1'b1, 2000, 1'b1);
        phase = "prio_short_timed";
        to_on();
        repeat (999) step(1'b1, 1'b0, 700, 1'b1);
        step(1'b1, 1'b0, 2000, 1'b1);
        phase = "prio_en_trip";
        to_on();
        step(1'b0, 1'b1, 2000, 1'b1);
        repeat (2) step(1'b0, 1'b0, 0, 1'b0);

        phase = "persistent_short";
        step(1'b0, 1'b0, 0, 1'b0);
        repeat (1400) step(1'b1, 1'b0, 2000, 1'b1);
        step(1'b0, 1'b0, 2000, 1'b1);

        phase = "async_reset";
        repeat (5) step(1'b1, 1'b0, 120, 1'b1);
        #3 rst = 1'b1;
        en = 1'b0;
        #1 model_reset();
        cmp(model_out(), "async_reset");
        @(negedge clk) rst = 1'b0;

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            int w, c;
            w = $urandom_range(0, 99);
            c = w < 60 ? $urandom_range(0, 500) : w < 95 ? $urandom_range(501, 700) : $urandom_range(1400, 2500);
            step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 199) == 0), c, 1'($urandom_range(0, 9) < 8));
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
